// File: rtl/cpu_monitor_pkg.sv
// Shared types and constants for the CPU run monitor and its trace buffer.
package cpu_monitor_pkg;

    typedef enum logic [1:0] {IDLE, RUN, HALT, DUMP} mon_state_e;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_TRAP    = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam logic [31:0] TRAP_DEFAULT = 32'h44000300;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } trace_entry_t;

endpackage

// File: rtl/trace_ring_buffer.sv
// Circular trace store: keeps the last DEPTH writes and replays them oldest first.
module trace_ring_buffer #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_start,
    input  logic                     rd_adv,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     rd_last
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, rd_cnt;

    // Storage needs no reset: fill gates what is ever read out.
    always_ff @(posedge clock)
        if (wr_en) mem[wr_ptr] <= wr_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            fill   <= '0;
            rd_ptr <= '0;
            rd_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (fill != FULL) fill <= fill + (AW+1)'(1);
            end
            // When full, wr_ptr - DEPTH wraps back to wr_ptr, the oldest slot.
            if (rd_start) begin
                rd_ptr <= wr_ptr - fill[AW-1:0];
                rd_cnt <= '0;
            end else if (rd_adv) begin
                rd_ptr <= rd_ptr + AW'(1);
                rd_cnt <= rd_cnt + AW'(1);
            end
        end
    end

    assign rd_data = mem[rd_ptr];
    assign rd_last = ({1'b0, rd_cnt} == fill - (AW+1)'(1));

endmodule

// File: rtl/cpu_run_monitor.sv
// Run-control monitor beside the CPU core: trap/watchdog halt, cycle and
// retire counters, and a post-halt trace drain over valid/ready.
module cpu_run_monitor
    import cpu_monitor_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter int          CNT_W     = 32,
    parameter int          TIMEOUT   = 150,
    parameter logic [31:0] TRAP_WORD = TRAP_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run_en,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    input  logic [31:0]      pc,
    output logic             halt,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count,
    input  logic             dump_req,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [31:0]      dump_pc,
    output logic [31:0]      dump_instr,
    output logic             dump_last
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    mon_state_e   state, state_nxt;
    logic [1:0]   cause_nxt;
    logic         active, retire, trap, timeout, start_dump, accept, rd_last;
    logic [AW:0]  fill;
    trace_entry_t wr_entry, rd_entry;

    assign active     = (state == RUN) && run_en;
    assign retire     = active && instr_valid;
    assign trap       = retire && (instr == TRAP_WORD);
    assign timeout    = active && (TIMEOUT != 0) && (cycle_count == TO_LAST);
    assign dump_valid = (state == DUMP);
    assign accept     = dump_valid && dump_ready;
    assign start_dump = (state == HALT) && dump_req && (fill != '0);
    assign halt       = (state == HALT) || (state == DUMP);
    assign wr_entry   = '{pc: pc, instr: instr};

    always_comb begin
        state_nxt = state;
        cause_nxt = halt_cause;
        case (state)
            IDLE: if (run_en) state_nxt = RUN;
            RUN: begin
                // Trap takes priority over a coincident watchdog expiry.
                if (trap) begin
                    state_nxt = HALT;
                    cause_nxt = CAUSE_TRAP;
                end else if (timeout) begin
                    state_nxt = HALT;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            HALT: if (start_dump) state_nxt = DUMP;
            DUMP: if (accept && rd_last) state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            halt_cause  <= CAUSE_NONE;
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            state      <= state_nxt;
            halt_cause <= cause_nxt;
            if (active && cycle_count != CNT_MAX) cycle_count <= cycle_count + CNT_W'(1);
            if (retire && instr_count != CNT_MAX) instr_count <= instr_count + CNT_W'(1);
        end
    end

    trace_ring_buffer #(.DEPTH(DEPTH), .WIDTH(64)) u_ring (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (retire),
        .wr_data  (wr_entry),
        .rd_start (start_dump),
        .rd_adv   (accept),
        .rd_data  (rd_entry),
        .fill     (fill),
        .rd_last  (rd_last)
    );

    assign dump_pc    = dump_valid ? rd_entry.pc    : '0;
    assign dump_instr = dump_valid ? rd_entry.instr : '0;
    assign dump_last  = dump_valid && rd_last;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Self-checking bench for cpu_run_monitor: vector table, directed corner
// sequences and randomized runs against a queue-based reference model.
module tb_cpu_run_monitor;
    localparam int          DEPTH = 16;
    localparam int          TO    = 150;
    localparam logic [31:0] TRAP  = 32'h44000300;

    logic        clock = 1'b0;
    logic        reset, run_en, instr_valid, dump_req, dump_ready;
    logic [31:0] instr, pc;
    logic        halt, dump_valid, dump_last;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_count, instr_count, dump_pc, dump_instr;

    always #5 clock = ~clock;

    cpu_run_monitor #(.DEPTH(DEPTH), .CNT_W(32), .TIMEOUT(TO), .TRAP_WORD(TRAP)) dut (
        .clock(clock), .reset(reset), .run_en(run_en), .instr_valid(instr_valid),
        .instr(instr), .pc(pc), .halt(halt), .halt_cause(halt_cause),
        .cycle_count(cycle_count), .instr_count(instr_count), .dump_req(dump_req),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_pc(dump_pc),
        .dump_instr(dump_instr), .dump_last(dump_last)
    );

    int n_chk = 0, n_pass = 0;

    // Reference model: plain flags, integer counters, bounded history queue.
    bit          m_run, m_halt;
    int          m_cause;
    longint      m_cyc, m_ins;
    logic [63:0] m_q[$];

    typedef struct {
        bit          ren, iv;
        logic [31:0] ins, p;
        bit          e_halt;
        logic [1:0]  e_cause;
        int          e_cyc, e_ins;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_clear;
        m_run = 0; m_halt = 0; m_cause = 0; m_cyc = 0; m_ins = 0;
        m_q.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_halt"}, halt, 0);
        chk({tag, "_cause"}, halt_cause, 0);
        chk({tag, "_cyc"}, cycle_count, 0);
        chk({tag, "_ins"}, instr_count, 0);
        chk({tag, "_dvalid"}, dump_valid, 0);
        chk({tag, "_dpc"}, dump_pc, 0);
        chk({tag, "_dinstr"}, dump_instr, 0);
        chk({tag, "_dlast"}, dump_last, 0);
    endtask

    task automatic do_reset;
        reset = 1; run_en = 0; instr_valid = 0; dump_req = 0; dump_ready = 0;
        instr = 0; pc = 0;
        @(posedge clock); #1;
        reset = 0;
        model_clear();
    endtask

    // One clock with the given inputs; outputs compared against the model 1 time unit after the edge.
    task automatic step(input bit ren, input bit iv, input logic [31:0] ins, input logic [31:0] p,
                        input bit dreq);
        bit is_trap, is_to;
        run_en = ren; instr_valid = iv; instr = ins; pc = p; dump_req = dreq;
        @(posedge clock); #1;
        if (!m_halt) begin
            if (!m_run) m_run = ren;
            else if (ren) begin
                is_trap = iv && (ins == TRAP);
                is_to   = (m_cyc == TO - 1);
                m_cyc++;
                if (iv) begin
                    m_q.push_back({p, ins});
                    if (m_q.size() > DEPTH) void'(m_q.pop_front());
                    m_ins++;
                end
                if (is_trap) begin m_halt = 1; m_cause = 1; end
                else if (is_to) begin m_halt = 1; m_cause = 2; end
            end
        end
        instr_valid = 0; dump_req = 0;
        chk("halt", halt, m_halt);
        chk("cause", halt_cause, m_cause);
        chk("cycles", cycle_count, m_cyc);
        chk("instrs", instr_count, m_ins);
        chk("dvalid_not_dumping", dump_valid, 0);
    endtask

    // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: random ready.
    task automatic drain(input int mode);
        int idx, guard, k;
        bit rdy;
        idx = 0; guard = 0; k = 0;
        dump_req = 1;
        @(posedge clock); #1;
        dump_req = 0;
        while (idx < m_q.size() && guard < 400) begin
            case (mode)
                0:       rdy = 1;
                1:       rdy = (k % 4 == 0) || (k % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            k++; guard++;
            dump_ready = rdy;
            chk("dump_valid", dump_valid, 1);
            chk("halt_in_dump", halt, 1);
            chk("dump_pc", dump_pc, m_q[idx][63:32]);
            chk("dump_instr", dump_instr, m_q[idx][31:0]);
            chk("dump_last", dump_last, (idx == m_q.size() - 1));
            @(posedge clock); #1;
            if (rdy) idx++;
        end
        dump_ready = 0;
        chk("drain_budget", guard < 400, 1);
        chk("dump_done_valid", dump_valid, 0);
        chk("dump_done_halt", halt, 1);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n, g;
        logic [31:0] p;
        bit seen_last;

        tbl[0] = '{1, 0, 32'h0,        32'h0,  0, 2'd0, 0, 0};
        tbl[1] = '{1, 1, 32'h00000013, 32'h0,  0, 2'd0, 1, 1};
        tbl[2] = '{0, 1, 32'h00000093, 32'h99, 0, 2'd0, 1, 1};
        tbl[3] = '{1, 1, 32'h00100113, 32'h4,  0, 2'd0, 2, 2};
        tbl[4] = '{1, 0, 32'h0,        32'h0,  0, 2'd0, 3, 2};
        tbl[5] = '{1, 1, 32'h00200193, 32'h8,  0, 2'd0, 4, 3};
        tbl[6] = '{1, 1, TRAP,         32'hC,  1, 2'd1, 5, 4};
        tbl[7] = '{1, 1, 32'h00000013, 32'h10, 1, 2'd1, 5, 4};

        // Reset state
        do_reset();
        chk_zero("rst");

        // Vector table: retire with a frozen cycle, then trap at pc 12
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].ren, tbl[i].iv, tbl[i].ins, tbl[i].p, 0);
            chk($sformatf("tbl%0d_halt", i), halt, tbl[i].e_halt);
            chk($sformatf("tbl%0d_cause", i), halt_cause, tbl[i].e_cause);
            chk($sformatf("tbl%0d_cyc", i), cycle_count, tbl[i].e_cyc);
            chk($sformatf("tbl%0d_ins", i), instr_count, tbl[i].e_ins);
        end
        drain(0);
        drain(1);   // stalled replay of identical data

        // Reset mid-RUN after 5 retires: outputs clear without a clock edge
        do_reset();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 32'h13, 32'(i * 4), 0);
        reset = 1;
        #2;
        chk_zero("midrun");
        @(posedge clock); #1;
        reset = 0;
        model_clear();
        step(1, 0, 0, 0, 0);
        step(1, 1, TRAP, 32'h100, 0);
        drain(0);   // single entry proves the old history was discarded

        // Wrap: 20 retires then trap at pc 80 -> oldest surviving is pc 20
        do_reset();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 1, 32'h1000 + 32'(i), 32'(i * 4), 0);
        step(1, 1, TRAP, 32'd80, 0);
        dump_req = 1; dump_ready = 1;
        @(posedge clock); #1;
        dump_req = 0;
        chk("wrap_first_pc", dump_pc, 20);
        n = 0; seen_last = 0; p = 0;
        while (!seen_last && n < 40) begin
            seen_last = dump_last;
            p = dump_pc;
            n++;
            @(posedge clock); #1;
        end
        dump_ready = 0;
        chk("wrap_count", n, 16);
        chk("wrap_last_pc", p, 80);
        drain(1);
        // Reset mid-DUMP
        dump_req = 1; dump_ready = 1;
        @(posedge clock); #1;
        dump_req = 0;
        @(posedge clock); #1;
        chk("middump_valid_before", dump_valid, 1);
        reset = 1;
        #2;
        chk_zero("middump");
        @(posedge clock); #1;
        reset = 0; dump_ready = 0;
        model_clear();

        // Watchdog: no trap, halt with cycle_count = TIMEOUT
        do_reset();
        g = 0;
        while (!m_halt && g < 300) begin step(1, 0, 0, 0, 0); g++; end
        chk("to_cycles", cycle_count, TO);
        chk("to_cause", halt_cause, 2);
        step(1, 1, TRAP, 32'h40, 0);     // trap after halt is ignored
        step(1, 0, 0, 0, 1);             // dump_req with empty buffer
        step(1, 0, 0, 0, 0);

        // Trap on the exact timeout cycle wins
        do_reset();
        step(1, 0, 0, 0, 0);
        while (m_cyc < TO - 1) step(1, 0, 0, 0, 0);
        step(1, 1, TRAP, 32'h200, 0);
        chk("tie_cause", halt_cause, 1);
        chk("tie_cycles", cycle_count, TO);
        drain(0);

        // Randomized runs against the model
        for (int it = 0; it < 8; it++) begin
            do_reset();
            p = 32'($urandom_range(0, 255)) << 2;
            g = 0;
            while (!m_halt && g < 400) begin
                step(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 24) == 0) ? TRAP : ($urandom() & 32'h3fffffff),
                     p, ($urandom_range(0, 9) == 0));
                p += 4;
                g++;
            end
            chk("rand_halted", halt, 1);
            drain(2);
            drain(0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
